// File: rtl/legv8_ctrl_pkg.sv
// Shared types and defaults for the LEGv8 phase controller.
package legv8_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEMORY    = 3'd4,
    WRITEBACK = 3'd5,
    HALT      = 3'd6,
    ERROR     = 3'd7
  } phase_e;

  localparam int MEM_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/phase_sequencer.sv
// Per-phase enable sequencer for the non-pipelined LEGv8 datapath, with
// run/step/halt control, memory-ready timeout and activity counters.
//
// state     | meaning
// IDLE      | waiting for run or step
// FETCH     | instruction memory read
// DECODE    | register read, decode controls latched
// EXECUTE   | ALU / branch adder capture
// MEMORY    | data access, held until mem_ready or timeout
// WRITEBACK | register write, PC update, instruction retires
// HALT      | stopped at an instruction boundary until reset
// ERROR     | memory never answered; stopped until reset
module phase_sequencer
  import legv8_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT   = MEM_TIMEOUT_DEFAULT,
  parameter int SKIP_IDLE_MEM = 1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             halt_req,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             reg_write,
  input  logic             mem_ready,
  output logic [2:0]       phase,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             execute_en,
  output logic             mem_en,
  output logic             writeback_en,
  output logic             pc_en,
  output logic             busy,
  output logic             halted,
  output logic             timeout_err,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retired_count
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  phase_e            state_q, state_d;
  logic              mr_q, mr_d;
  logic              mw_q, mw_d;
  logic              rw_q, rw_d;
  logic              halt_q, halt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              stop_now;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      rw_q    <= 1'b0;
      halt_q  <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      mr_q    <= mr_d;
      mw_q    <= mw_d;
      rw_q    <= rw_d;
      halt_q  <= halt_d;
      wait_q  <= wait_d;
    end
  end

  // A halt request is remembered so it takes effect at the next boundary.
  assign stop_now = halt_req | halt_q;

  always_comb begin
    state_d = state_q;
    mr_d    = mr_q;
    mw_d    = mw_q;
    rw_d    = rw_q;
    halt_d  = stop_now;
    wait_d  = wait_q;
    case (state_q)
      IDLE: begin
        if (stop_now)         state_d = HALT;
        else if (run || step) state_d = FETCH;
      end
      FETCH: state_d = DECODE;
      DECODE: begin
        mr_d    = mem_read;
        mw_d    = mem_write;
        rw_d    = reg_write;
        state_d = EXECUTE;
      end
      EXECUTE: begin
        wait_d = '0;
        if (!(mr_q || mw_q) && (SKIP_IDLE_MEM != 0)) state_d = WRITEBACK;
        else                                         state_d = MEMORY;
      end
      MEMORY: begin
        if (mem_ready)                state_d = WRITEBACK;
        else if (wait_q == WAIT_LAST) state_d = ERROR;
        else                          wait_d  = wait_q + 1'b1;
      end
      WRITEBACK: begin
        if (stop_now) state_d = HALT;
        else if (run) state_d = FETCH;
        else          state_d = IDLE;
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    fetch_en     = 1'b0;
    decode_en    = 1'b0;
    execute_en   = 1'b0;
    mem_en       = 1'b0;
    writeback_en = 1'b0;
    pc_en        = 1'b0;
    busy         = 1'b0;
    halted       = 1'b0;
    timeout_err  = 1'b0;
    case (state_q)
      FETCH:   begin fetch_en   = 1'b1; busy = 1'b1; end
      DECODE:  begin decode_en  = 1'b1; busy = 1'b1; end
      EXECUTE: begin execute_en = 1'b1; busy = 1'b1; end
      MEMORY:  begin mem_en     = 1'b1; busy = 1'b1; end
      WRITEBACK: begin
        writeback_en = rw_q;
        pc_en        = 1'b1;
        busy         = 1'b1;
      end
      HALT:    halted      = 1'b1;
      ERROR:   timeout_err = 1'b1;
      default: ;
    endcase
  end

  assign phase = state_q;

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc   (busy),
    .clear (1'b0),
    .count (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_retired_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc   (pc_en),
    .clear (1'b0),
    .count (retired_count)
  );

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Single-clock controller that sequences the non-pipelined LEGv8 datapath through its instruction phases: Fetch, Decode, Execute, Memory and Writeback.
- Replaces the chain of delayed phase clocks with per-phase enables derived from one clock.
- Sits beside the Fetch/Decode/Execute/Memory/Writeback stages; drives their enables and the PC update.
- Provides run/step/halt debug control, a data-memory ready handshake with timeout, and cycle/retired-instruction counters.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles spent in MEMORY waiting for mem_ready before a fatal error.
- SKIP_IDLE_MEM, 1: when 1, MEMORY is bypassed for instructions with neither mem_read nor mem_write.
- CNT_W, 32: width of cycle_count and retired_count.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- run  in  1  level; 1 = free-run instructions back-to-back.
- step  in  1  single-cycle pulse; executes exactly one instruction from IDLE.
- halt_req  in  1  request to stop at the next instruction boundary; sticky until reset.
- mem_read  in  1  decode control, sampled in DECODE.
- mem_write  in  1  decode control, sampled in DECODE.
- reg_write  in  1  decode control, sampled in DECODE.
- mem_ready  in  1  data memory has completed the access this cycle.
- phase  out  3  current state encoding (package enum).
- fetch_en  out  1  instruction memory read enable.
- decode_en  out  1  register file read enable.
- execute_en  out  1  ALU / branch-adder result capture.
- mem_en  out  1  data memory access strobe.
- writeback_en  out  1  register file write enable (= latched reg_write).
- pc_en  out  1  PC register update enable.
- busy  out  1  1 in FETCH through WRITEBACK.
- halted  out  1  1 in HALT.
- timeout_err  out  1  1 in ERROR.
- cycle_count  out  CNT_W  busy cycles, saturating.
- retired_count  out  CNT_W  completed instructions, saturating.

Behaviour:
- Reset (reset=0, async): state=IDLE; all enables, busy, halted and timeout_err = 0; counters = 0; latched controls = 0.
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT, ERROR. Outputs are Moore, decoded from state only.
- IDLE:
  - halt_req=1 -> HALT.
  - Otherwise run=1 or step=1 -> FETCH; run and step together behave as run.
  - Otherwise stay in IDLE.
- FETCH: fetch_en=1, 1 cycle -> DECODE.
- DECODE: decode_en=1, 1 cycle. Latch mem_read, mem_write and reg_write into mr_q, mw_q and rw_q -> EXECUTE.
- EXECUTE: execute_en=1, 1 cycle.
  - (mr_q|mw_q)=0 and SKIP_IDLE_MEM=1 -> WRITEBACK.
  - Otherwise -> MEMORY.
- MEMORY: mem_en=1 for as long as this state is held.
  - mem_ready=1 -> WRITEBACK.
  - Wait counter clears on entry and increments each cycle without mem_ready.
  - Counter reaches MEM_TIMEOUT with mem_ready still 0 -> ERROR.
  - With SKIP_IDLE_MEM=0 and no access pending, mem_ready is still required to leave.
- WRITEBACK: writeback_en=rw_q, pc_en=1; retired_count +1. Next state:
  - halt_req (or its latched copy) = 1 -> HALT.
  - run=1 -> FETCH.
  - Otherwise -> IDLE.
- HALT and ERROR: absorbing until reset; all enables 0.
- halt_req seen mid-instruction is latched and never aborts the current instruction.
- Latency, no memory access (SKIP_IDLE_MEM=1): 4 cycles.
- Latency, memory access: 5+W cycles, where W = cycles before mem_ready.
- cycle_count: +1 every cycle busy=1.
- Both counters saturate at all-ones and never wrap.
- reset asserted mid-instruction: immediate return to the reset state. No partial pc_en or writeback_en pulse may occur after reset asserts.

Decomposition:
- Shared package legv8_ctrl_pkg holds:
  - phase_e enum: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6, ERROR=7.
  - Default MEM_TIMEOUT constant.
- One sub-module sat_counter (parameter W; ports inc and clear; async active-low reset), instantiated for cycle_count and retired_count.

Test Plan:
1. Reset low for 3 cycles, then high with run=0 -> phase=IDLE, all enables 0, counters 0, no state change for 10 cycles.
2. run=1, all decode controls 0 (ADD-like), SKIP_IDLE_MEM=1 -> F,D,E,WB repeating every 4 cycles; pc_en pulses once per 4 cycles; after 3 instructions retired_count=3 and cycle_count=12.
3. step pulse with mem_read=1, mem_ready asserted on the 3rd MEMORY cycle -> mem_en high for 3 cycles; WB then IDLE; retired_count=1, cycle_count=7.
4. mem_write=1, mem_ready held 0, MEM_TIMEOUT=16 -> ERROR after 16 MEMORY cycles, timeout_err=1, retired_count unchanged; stays in ERROR until reset.
5. halt_req pulsed during EXECUTE while run=1 -> instruction completes through WB, then HALT with halted=1; later run/step ignored.
6. reset asserted during MEMORY -> immediate IDLE, counters 0, no writeback_en or pc_en pulse; CNT_W=4 with run -> retired_count saturates at 15.
